// File: rtl/code_packer_pkg.sv
// Shared types and width helpers for the code_packer bit packer.
package code_packer_pkg;

  typedef enum logic [1:0] {RUN, PAD, DRAIN, LAST} state_t;

  localparam logic [7:0] STUFF_BYTE = 8'hFF;
  localparam logic [7:0] STUFF_FILL = 8'h00;

  // Fill counter must hold 0..acc_w inclusive.
  function automatic int fill_width(input int acc_w);
    return $clog2(acc_w) + 1;
  endfunction

  // Byte counter must hold 0..out_w/8 inclusive.
  function automatic int nbytes_width(input int out_w);
    return $clog2(out_w / 8) + 1;
  endfunction

endpackage

// File: rtl/code_packer_byte_assembler.sv
// Collects bytes MSB-first into OUT_W-bit words and owns the registered
// valid/ready output slot; a flush request closes out a partial word as last.
module byte_assembler
  import code_packer_pkg::*;
#(
  parameter int OUT_W = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             byte_valid,
  output logic                             byte_ready,
  input  logic [7:0]                       byte_data,
  input  logic                             flush_req,
  output logic                             flush_ack,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [OUT_W-1:0]                 out_data,
  output logic [nbytes_width(OUT_W)-1:0]   out_nbytes,
  output logic                             out_last
);

  localparam int NBYTES = OUT_W / 8;
  localparam int NB_W   = nbytes_width(OUT_W);

  logic [OUT_W-1:0] word_reg, base_word, word_next;
  logic [NB_W-1:0]  cnt_reg, base_cnt, cnt_next;
  logic             out_valid_reg, out_last_reg;
  logic [OUT_W-1:0] out_data_reg;
  logic [NB_W-1:0]  out_nbytes_reg;
  logic             full, slot_free, move, take;

  assign full       = (cnt_reg == NB_W'(NBYTES));
  assign slot_free  = !out_valid_reg || out_ready;
  assign move       = slot_free && (full || (flush_req && cnt_reg != '0));
  assign byte_ready = !full || slot_free;
  assign take       = byte_valid && byte_ready;
  assign flush_ack  = flush_req && (cnt_reg == '0 || slot_free);

  // A departing word frees the register in the same cycle a new byte lands.
  assign base_word = move ? '0 : word_reg;
  assign base_cnt  = move ? '0 : cnt_reg;
  assign cnt_next  = take ? base_cnt + NB_W'(1) : base_cnt;

  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
    assign word_next[OUT_W-1-8*gi -: 8] =
      (take && base_cnt == NB_W'(gi)) ? byte_data : base_word[OUT_W-1-8*gi -: 8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_reg       <= '0;
      cnt_reg        <= '0;
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      out_nbytes_reg <= '0;
      out_last_reg   <= 1'b0;
    end else begin
      word_reg <= word_next;
      cnt_reg  <= cnt_next;
      if (move) begin
        out_valid_reg  <= 1'b1;
        out_data_reg   <= word_reg;
        out_nbytes_reg <= cnt_reg;
        out_last_reg   <= flush_req;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid  = out_valid_reg;
  assign out_data   = out_data_reg;
  assign out_nbytes = out_nbytes_reg;
  assign out_last   = out_last_reg;

endmodule

// File: rtl/code_packer.sv
// Variable-length code packer: MSB-first bit accumulator feeding a byte
// assembler. Optional 0xFF/0x00 byte stuffing with CODE_PACKER_STUFF_EN.
module code_packer
  import code_packer_pkg::*;
#(
  parameter int CODE_W = 32,
  parameter int OUT_W  = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [CODE_W-1:0]                in_code,
  input  logic [$clog2(CODE_W):0]          in_size,
  input  logic                             in_flush,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [OUT_W-1:0]                 out_data,
  output logic [nbytes_width(OUT_W)-1:0]   out_nbytes,
  output logic                             out_last
);

  localparam int ACC_W  = 2 * CODE_W;
  localparam int FILL_W = fill_width(ACC_W);
  localparam int SIZE_W = $clog2(CODE_W) + 1;

  state_t             state_reg, state_next;
  logic [ACC_W-1:0]   acc_reg, acc_next, acc_after, app_bits;
  logic [FILL_W-1:0]  fill_reg, fill_next, fill_after, app_size, app_shift;
  logic               app_en, accept, extract, drained;
  logic               stuff_pend;
  logic               byte_valid, byte_ready;
  logic [7:0]         byte_data;
  logic               flush_req, flush_ack;

  assign in_ready   = !rst && state_reg == RUN && fill_reg <= FILL_W'(ACC_W - CODE_W);
  assign accept     = in_valid && in_ready;
  assign byte_valid = stuff_pend || fill_reg >= FILL_W'(8);
  assign byte_data  = stuff_pend ? STUFF_FILL : acc_reg[ACC_W-1 -: 8];
  assign extract    = byte_valid && byte_ready && !stuff_pend;
  // Flush is complete once every bit (and any pending stuff byte) has left.
  assign drained    = (state_reg == PAD || state_reg == DRAIN) && fill_reg == '0 && !stuff_pend;
  assign flush_req  = drained || state_reg == LAST;

`ifdef CODE_PACKER_STUFF_EN
  logic stuff_pend_reg;
  always_ff @(posedge clk) begin
    if (rst) begin
      stuff_pend_reg <= 1'b0;
    end else if (byte_valid && byte_ready) begin
      stuff_pend_reg <= !stuff_pend_reg && acc_reg[ACC_W-1 -: 8] == STUFF_BYTE;
    end
  end
  assign stuff_pend = stuff_pend_reg;
`else
  assign stuff_pend = 1'b0;
`endif

  // Extraction shifts the top byte out; new bits land just below what remains.
  always_comb begin
    fill_after = extract ? fill_reg - FILL_W'(8) : fill_reg;
    acc_after  = extract ? acc_reg << 8 : acc_reg;
    app_en     = 1'b0;
    app_size   = '0;
    app_bits   = '0;
    if (state_reg == RUN && accept && !in_flush) begin
      app_en   = 1'b1;
      app_size = FILL_W'(in_size);
      app_bits = ACC_W'(in_code);
    end else if (state_reg == PAD && fill_reg[2:0] != 3'd0) begin
      app_en   = 1'b1;
      app_size = FILL_W'(8) - FILL_W'(fill_reg[2:0]);
      app_bits = '1;
    end
    app_bits  = app_bits & ~({ACC_W{1'b1}} << app_size);
    app_shift = FILL_W'(ACC_W) - fill_after - app_size;
    acc_next  = acc_after | (app_en ? app_bits << app_shift : '0);
    fill_next = fill_after + app_size;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:     if (accept && in_flush) state_next = PAD;
      PAD:     state_next = DRAIN;
      DRAIN:   if (drained) state_next = LAST;
      LAST:    if (flush_ack) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= RUN;
      acc_reg   <= '0;
      fill_reg  <= '0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      fill_reg  <= fill_next;
    end
  end

  assert property (@(posedge clk) disable iff (rst)
    (accept && !in_flush) |-> (in_size <= SIZE_W'(CODE_W)));

  byte_assembler #(.OUT_W(OUT_W)) u_asm (
    .clk        (clk),
    .rst        (rst),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .byte_data  (byte_data),
    .flush_req  (flush_req),
    .flush_ack  (flush_ack),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_nbytes (out_nbytes),
    .out_last   (out_last)
  );

endmodule

// File: tb/tb_code_packer.sv
// Scoreboard bench for code_packer (CODE_W=32, OUT_W=16); expectations follow
// CODE_PACKER_STUFF_EN when it is defined.
`timescale 1ns/1ps
module tb_code_packer;

  localparam int CODE_W = 32;
  localparam int OUT_W  = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_flush;
  logic [31:0] in_code;
  logic [5:0]  in_size;
  logic        out_valid, out_ready, out_last;
  logic [15:0] out_data;
  logic [1:0]  out_nbytes;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  nb;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   rdy_mode = 0;

  always #5 clk = ~clk;

  code_packer #(.CODE_W(CODE_W), .OUT_W(OUT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_code    (in_code),
    .in_size    (in_size),
    .in_flush   (in_flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_nbytes (out_nbytes),
    .out_last   (out_last)
  );

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: every accepted output word is popped against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_word: got data=%h nbytes=%0d last=%0b, required no word",
                 out_data, out_nbytes, out_last);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e.data || out_nbytes !== e.nb || out_last !== e.last) begin
          n_errors++;
          $display("FAIL word: got data=%h nbytes=%0d last=%0b, required data=%h nbytes=%0d last=%0b",
                   out_data, out_nbytes, out_last, e.data, e.nb, e.last);
        end else begin
          $display("word data=%h nbytes=%0d last=%0b ok", out_data, out_nbytes, out_last);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end else begin
      $display("check %s ok: %h", name, got);
    end
  endtask

  task automatic expect_word(input logic [15:0] d, input logic [1:0] nb, input logic l);
    exp_t e;
    e.data = d;
    e.nb   = nb;
    e.last = l;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] code, input int size, input logic flush);
    int budget;
    budget   = 0;
    in_valid = 1'b1;
    in_code  = code;
    in_size  = 6'(size);
    in_flush = flush;
    @(negedge clk);
    while (!in_ready && budget < 500) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: got in_ready=0 for %0d cycles, required 1", budget);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_flush = 1'b0;
  endtask

  task automatic wait_empty();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    check("drain_queue", 32'(exp_q.size()), 32'd0);
    repeat (5) @(posedge clk);
    #1;
  endtask

  initial begin
    int seen;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_code  = '0;
    in_size  = '0;
    in_flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid",  32'(out_valid),  32'd0);
    check("rst_out_last",   32'(out_last),   32'd0);
    check("rst_out_nbytes", 32'(out_nbytes), 32'd0);
    check("rst_out_data",   32'(out_data),   32'd0);
    check("rst_in_ready",   32'(in_ready),   32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // 11-bit + 7-bit codes (upper junk masked), flush pads with ones.
    expect_word(16'h8030, 2'd2, 1'b0);
    expect_word(16'h7F00, 2'd1, 1'b1);
    send(32'hDEADFC01, 11, 1'b0);
    send(32'h123456C1, 7, 1'b0);
    send(32'h0, 0, 1'b1);
    wait_empty();

`ifdef CODE_PACKER_STUFF_EN
    expect_word(16'hFF00, 2'd2, 1'b0);
    expect_word(16'h1200, 2'd1, 1'b1);
`else
    expect_word(16'hFF12, 2'd2, 1'b1);
`endif
    send(32'h000000FF, 8, 1'b0);
    send(32'h00000012, 8, 1'b0);
    send(32'h0, 0, 1'b1);
    wait_empty();

    // Empty flushes and zero-size codes produce nothing.
    send(32'h0, 0, 1'b1);
    send(32'hFFFFFFFF, 0, 1'b0);
    send(32'h00000005, 0, 1'b0);
    send(32'h0, 0, 1'b1);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("noop_no_output", 32'(seen), 32'd0);
    check("noop_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Backpressure: 16 full-width codes, output blocked then random.
    rdy_mode = 1;
    for (int i = 0; i < 32; i++) expect_word(16'hA5A5, 2'd2, i == 31);
    fork
      begin
        for (int k = 0; k < 16; k++) send(32'hA5A5A5A5, 32, 1'b0);
        send(32'h0, 0, 1'b1);
      end
      begin
        repeat (20) @(negedge clk);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        rdy_mode = 2;
      end
    join
    wait_empty();
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;

    expect_word(16'hBF00, 2'd1, 1'b1);
    send(32'hFFFFFFFD, 3, 1'b0);
    send(32'h0, 0, 1'b1);
    wait_empty();

    // Reset while a flush is stuck draining behind a blocked output.
    rdy_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    send(32'h12345678, 32, 1'b0);
    send(32'h9ABCDEF0, 32, 1'b0);
    send(32'h0, 0, 1'b1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    rdy_mode = 0;
    @(negedge clk);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready_after", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    expect_word(16'h3CC3, 2'd2, 1'b1);
    send(32'h0000003C, 8, 1'b0);
    send(32'h000000C3, 8, 1'b0);
    send(32'h0, 0, 1'b1);
    wait_empty();

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
